motor_speed_ctrl: RTL



---
 rtl/motor_speed_ctrl_pkg.sv | 12 +
 rtl/motor_speed_ctrl_if.sv | 22 ++
 rtl/motor_speed_ctrl_timer.sv | 21 ++
 rtl/motor_speed_ctrl.sv | 105 ++++++++++
 4 files changed

// File: rtl/motor_speed_ctrl_pkg.sv
// motor_pkg: state encodings, widths and default timing shared across the motor_driver blocks
package motor_pkg;
    localparam int DUTY_W = 8;
    localparam int CNT_W = 32;
    localparam int DEF_CLOCK_FREQ_HZ = 100_000_000;
    localparam int DEF_DUTY_STEP = 1;
    localparam int DEF_DUTY_MIN = 8;
    localparam int DEF_DUTY_MAX = 255;
    localparam int DEF_KICK_DUTY = 160;
    localparam int DEF_DEADBAND = 16;
    typedef enum logic [1:0] {ST_IDLE, ST_KICK, ST_TRACK, ST_STALL} state_t;
endpackage

// File: rtl/motor_speed_ctrl_if.sv
// motor_speed_ctrl_if: encoder/software inputs and duty/status outputs of the speed controller
interface motor_speed_ctrl_if;
    import motor_pkg::*;
    logic              enable;
    logic [CNT_W-1:0]  setpoint;
    logic [CNT_W-1:0]  count_high;
    logic              count_ready;
    logic              motor_is_running;
    logic [DUTY_W-1:0] duty;
    logic              duty_update;
    logic              at_speed;
    logic              stalled;
    logic [1:0]        state;
    modport master (
        output enable, setpoint, count_high, count_ready, motor_is_running,
        input  duty, duty_update, at_speed, stalled, state
    );
    modport slave (
        input  enable, setpoint, count_high, count_ready, motor_is_running,
        output duty, duty_update, at_speed, stalled, state
    );
endinterface

// File: rtl/motor_speed_ctrl_timer.sv
// ctrl_timer: loadable down-counter that stops at zero and flags it
module ctrl_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= val_i;
        else if (dec_i && cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/motor_speed_ctrl.sv
// motor_speed_ctrl: kick/track/stall sequencer stepping PWM duty toward an encoder period setpoint
module motor_speed_ctrl
    import motor_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ = DEF_CLOCK_FREQ_HZ,
    parameter int DUTY_STEP     = DEF_DUTY_STEP,
    parameter int DUTY_MIN      = DEF_DUTY_MIN,
    parameter int DUTY_MAX      = DEF_DUTY_MAX,
    parameter int KICK_DUTY     = DEF_KICK_DUTY,
    parameter int KICK_CYCLES   = CLOCK_FREQ_HZ / 20,
    parameter int DEADBAND      = DEF_DEADBAND,
    parameter int STALL_CYCLES  = CLOCK_FREQ_HZ / 5
) (
    input logic               clk,
    input logic               reset_n,
    motor_speed_ctrl_if.slave bus
);
    localparam logic signed [CNT_W:0] DB = (CNT_W+1)'(DEADBAND);
    localparam logic [DUTY_W:0] STEP9 = (DUTY_W+1)'(DUTY_STEP);
    localparam logic [DUTY_W:0] MIN9 = (DUTY_W+1)'(DUTY_MIN);
    localparam logic [DUTY_W:0] MAX9 = (DUTY_W+1)'(DUTY_MAX);
    state_t              state_q;
    logic                cr_q;
    logic [DUTY_W-1:0]   duty_q;
    logic                upd_q, at_speed_q, stalled_q;
    logic                sample, stop, active, expired, up, dn, load;
    logic signed [CNT_W:0] err;
    logic [DUTY_W:0]     sum;
    logic [DUTY_W-1:0]   duty_d;
    logic [CNT_W-1:0]    load_val;
    assign sample = bus.count_ready && !cr_q;
    assign stop = !bus.enable || bus.setpoint == '0;
    assign active = state_q == ST_KICK || state_q == ST_TRACK;
    assign err = $signed({1'b0, bus.count_high}) - $signed({1'b0, bus.setpoint});
    assign up = err > DB;
    assign dn = err < -DB;
    // 9-bit sum so the ceiling clamp sees the carry instead of a wrapped value
    assign sum = {1'b0, duty_q} + STEP9;
    assign duty_d = up ? (sum > MAX9 ? MAX9[DUTY_W-1:0] : sum[DUTY_W-1:0])
                  : dn ? ({1'b0, duty_q} >= MIN9 + STEP9 ? duty_q - STEP9[DUTY_W-1:0] : MIN9[DUTY_W-1:0])
                  : duty_q;
    assign load = state_q == ST_IDLE ? !stop
                : active && !stop && (sample || (state_q == ST_KICK && expired && bus.motor_is_running));
    assign load_val = state_q == ST_IDLE ? CNT_W'(KICK_CYCLES) : CNT_W'(STALL_CYCLES);
    ctrl_timer #(.W(CNT_W)) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .load_i (load),
        .val_i  (load_val),
        .dec_i  (active),
        .zero_o (expired)
    );
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cr_q       <= 1'b0;
            duty_q     <= '0;
            upd_q      <= 1'b0;
            at_speed_q <= 1'b0;
            stalled_q  <= 1'b0;
        end else begin
            cr_q  <= bus.count_ready;
            upd_q <= 1'b0;
            case (state_q)
                ST_IDLE:
                    if (!stop) begin
                        state_q <= ST_KICK;
                        duty_q  <= DUTY_W'(KICK_DUTY);
                        upd_q   <= 1'b1;
                    end
                ST_KICK, ST_TRACK:
                    if (stop) begin
                        state_q    <= ST_IDLE;
                        duty_q     <= '0;
                        upd_q      <= duty_q != '0;
                        at_speed_q <= 1'b0;
                    end else if (sample) begin
                        state_q <= ST_TRACK;
                        if (state_q == ST_TRACK) begin
                            duty_q     <= duty_d;
                            upd_q      <= duty_d != duty_q;
                            at_speed_q <= !(up || dn);
                        end
                    end else if (expired && state_q == ST_KICK && bus.motor_is_running) begin
                        state_q <= ST_TRACK;
                    end else if (expired) begin
                        state_q    <= ST_STALL;
                        duty_q     <= '0;
                        upd_q      <= duty_q != '0;
                        at_speed_q <= 1'b0;
                        stalled_q  <= 1'b1;
                    end
                default:
                    if (!bus.enable) begin
                        state_q   <= ST_IDLE;
                        stalled_q <= 1'b0;
                    end
            endcase
        end
    assign bus.duty = duty_q;
    assign bus.duty_update = upd_q;
    assign bus.at_speed = at_speed_q;
    assign bus.stalled = stalled_q;
    assign bus.state = state_q;
endmodule
